dmem_bus_master: RTL and testbench

Memory-stage data-bus master for the pipelined MIPS core. Converts `lw`/`sw` accesses in the M stage into a registered req/ack transaction toward a variable-latency data memory. It raises `stall_M` toward the hazard unit while a transaction is outstanding, so the whole pipeline freezes until the memory responds. It is the stall *source* paired with the hazard unit's stall/flush *consumer* logic: `stall_M` is OR-ed into the hazard unit's `stall`.

---
 rtl/dmem_bus_master.sv | 129 ++++++++++++
 tb/tb_dmem_bus_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_bus_master                                                 |
// | Purpose  : M-stage lw/sw to registered req/ack data-bus master with stall  |
// |            output. Optional REQ timeout enabled by DMEM_TIMEOUT_EN.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dmem_bus_master #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_read_M,
    input  logic              mem_write_M,
    input  logic [DATA_W-1:0] alu_out_M,
    input  logic [DATA_W-1:0] write_data_M,
    output logic [DATA_W-1:0] read_data_M,
    output logic              stall_M,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [DATA_W-1:0] c_ALIGN_MASK = {{(DATA_W-2){1'b1}}, 2'b00};

    logic [1:0]        r_state;
    logic              r_req;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_op;
    logic              w_timeout;

    assign w_op = mem_read_M | mem_write_M;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT = TIMEOUT[7:0];

    logic [7:0] r_cnt;
    logic       r_err;

    // Fires on the REQ cycle that would make the no-ack count reach TIMEOUT;
    // an ack in that same cycle takes priority.
    assign w_timeout = (r_state == c_REQ) && !bus_ack && ((r_cnt + 8'd1) == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            if (r_state == c_IDLE) begin
                r_cnt <= 8'd0;
            end else if ((r_state == c_REQ) && !bus_ack) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_op) begin
                        r_addr  <= alu_out_M & c_ALIGN_MASK;
                        r_we    <= mem_write_M;
                        r_wdata <= write_data_M;
                        r_req   <= 1'b1;
                        r_state <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (bus_ack) begin
                        if (!r_we) begin
                            r_rdata <= bus_rdata;
                        end
                        r_req   <= 1'b0;
                        r_state <= c_DONE;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_req   <= 1'b0;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // DONE deliberately never stalls so the completed instruction advances.
    assign stall_M     = (r_state == c_REQ) || ((r_state == c_IDLE) && w_op);
    assign bus_req     = r_req;
    assign bus_we      = r_we;
    assign bus_addr    = r_addr;
    assign bus_wdata   = r_wdata;
    assign read_data_M = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_bus_master                                              |
// | Purpose  : Self-checking bench: vector table, corner sequences and random   |
// |            transactions against a transaction-level memory model.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dmem_bus_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_read_M;
    logic        mem_write_M;
    logic [31:0] alu_out_M;
    logic [31:0] write_data_M;
    logic [31:0] read_data_M;
    logic        stall_M;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        exp_err = 1'b0;
    logic [31:0] last_rd = 32'h0;

    dmem_bus_master #(.DATA_W(32), .TIMEOUT(15)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_read_M   (mem_read_M),
        .mem_write_M  (mem_write_M),
        .alu_out_M    (alu_out_M),
        .write_data_M (write_data_M),
        .read_data_M  (read_data_M),
        .stall_M      (stall_M),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [5];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        mem_read_M  = 1'b0;
        mem_write_M = 1'b0;
        bus_ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_err = 1'b0;
        last_rd = 32'h0;
    endtask

    // Called just after a posedge with the DUT in IDLE; returns just after the
    // posedge that leaves DONE, so a following call is back-to-back.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                           input logic [31:0] exp_addr, input logic exp_we, input logic [31:0] exp_rd);
        int stalls = 0;
        mem_read_M   = rd;
        mem_write_M  = wr;
        alu_out_M    = addr;
        write_data_M = wdata;
        bus_ack      = 1'b0;
        @(negedge clk);
        chk1("idle_stall", stall_M, 1'b1);
        chk1("idle_req", bus_req, 1'b0);
        if (stall_M) stalls++;
        for (int k = 0; k <= waits; k++) begin
            @(posedge clk); #1;
            bus_ack   = (k == waits);
            bus_rdata = (k == waits) ? rdata : $urandom;
            alu_out_M    = $urandom;
            write_data_M = $urandom;
            @(negedge clk);
            chk1("req_stall", stall_M, 1'b1);
            chk1("req_req", bus_req, 1'b1);
            chk32("req_addr", bus_addr, exp_addr);
            chk1("req_we", bus_we, exp_we);
            if (exp_we) chk32("req_wdata", bus_wdata, wdata);
            if (stall_M) stalls++;
        end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk1("done_stall", stall_M, 1'b0);
        chk1("done_req", bus_req, 1'b0);
        chk32("done_rdata", read_data_M, exp_rd);
        chk1("done_err", bus_err, exp_err);
        chk32("stall_cycles", stalls, waits + 2);
        @(posedge clk); #1;
        mem_read_M  = 1'b0;
        mem_write_M = 1'b0;
        last_rd     = exp_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,          32'hCAFE_F00D, 0, 32'h0000_0010, 1'b0, 32'hCAFE_F00D};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'h5555_5555, 3, 32'h0000_0040, 1'b1, 32'hCAFE_F00D};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,          32'hDEAD_BEEF, 0, 32'h0000_0100, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h0,          0, 32'hFFFF_FFFC, 1'b1, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0009, 32'h0F0F_0F0F, 32'h1111_1111, 2, 32'h0000_0008, 1'b1, 32'hDEAD_BEEF};

        alu_out_M    = 32'h0;
        write_data_M = 32'h0;
        bus_rdata    = 32'h0;
        do_reset();

        // Reset values.
        @(negedge clk);
        chk1("rst_req", bus_req, 1'b0);
        chk1("rst_we", bus_we, 1'b0);
        chk1("rst_err", bus_err, 1'b0);
        chk1("rst_stall", stall_M, 1'b0);
        chk32("rst_addr", bus_addr, 32'h0);
        chk32("rst_wdata", bus_wdata, 32'h0);
        chk32("rst_rdata", read_data_M, 32'h0);

        // Reset during REQ, then a late ack.
        @(posedge clk); #1;
        mem_read_M = 1'b1;
        alu_out_M  = 32'h0000_0044;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk1("rstmid_req_before", bus_req, 1'b1);
        @(posedge clk); #1;
        reset_n    = 1'b1;
        mem_read_M = 1'b0;
        bus_ack    = 1'b1;
        bus_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        chk1("rstmid_req", bus_req, 1'b0);
        chk1("rstmid_stall", stall_M, 1'b0);
        chk32("rstmid_addr", bus_addr, 32'h0);
        chk32("rstmid_rdata", read_data_M, 32'h0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk1("rstmid_req2", bus_req, 1'b0);
        chk1("rstmid_stall2", stall_M, 1'b0);
        chk32("rstmid_rdata2", read_data_M, 32'h0);
        @(posedge clk); #1;

        // Vector table, applied back-to-back.
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                    vecs[i].waits, vecs[i].exp_addr, vecs[i].exp_we, vecs[i].exp_rd);
        end

        // Spurious ack in IDLE with no access.
        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_7777;
        @(negedge clk);
        chk1("spur_stall", stall_M, 1'b0);
        chk1("spur_req", bus_req, 1'b0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk1("spur_stall2", stall_M, 1'b0);
        chk1("spur_req2", bus_req, 1'b0);
        chk32("spur_rdata", read_data_M, last_rd);
        @(posedge clk); #1;

        // Random transactions against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            int          sel;
            int          gap;
            logic        rd;
            logic        wr;
            logic [31:0] addr;
            logic [31:0] wd;
            logic [31:0] rdv;
            sel  = $urandom_range(0, 2);
            rd   = (sel != 1);
            wr   = (sel != 0);
            addr = $urandom;
            wd   = $urandom;
            rdv  = $urandom;
            run_txn(rd, wr, addr, wd, rdv, $urandom_range(0, 4),
                    addr & 32'hFFFF_FFFC, wr, wr ? last_rd : rdv);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk1("gap_stall", stall_M, 1'b0);
                @(posedge clk); #1;
            end
        end

`ifdef DMEM_TIMEOUT_EN
        do_reset();
        run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0077, 0, 32'h0000_0020, 1'b0, 32'h0000_0077);
        mem_read_M = 1'b1;
        alu_out_M  = 32'h0000_0030;
        @(posedge clk); #1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk1("to_wait_stall", stall_M, 1'b1);
            chk1("to_wait_err", bus_err, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk1("to_done_stall", stall_M, 1'b0);
        chk1("to_done_req", bus_req, 1'b0);
        chk1("to_done_err", bus_err, 1'b1);
        chk32("to_done_rdata", read_data_M, 32'h0);
        @(posedge clk); #1;
        mem_read_M = 1'b0;
        exp_err    = 1'b1;
        run_txn(1'b1, 1'b0, 32'h0000_0050, 32'h0, 32'h0000_ABCD, 1, 32'h0000_0050, 1'b0, 32'h0000_ABCD);
        do_reset();
        run_txn(1'b1, 1'b0, 32'h0000_0060, 32'h0, 32'h0000_1515, 14, 32'h0000_0060, 1'b0, 32'h0000_1515);
`else
        // Without the timeout a long wait simply stalls and completes normally.
        run_txn(1'b1, 1'b0, 32'h0000_0060, 32'h0, 32'h0000_1515, 20, 32'h0000_0060, 1'b0, 32'h0000_1515);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
